mem_access_unit: RTL and testbench

//  MEM-stage load/store unit between EX/MEM and MEM/WB. Turns EX/MEM memory ops into

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store ops into req/ack data-memory
// transactions, formats load data and stalls the pipeline until completion or timeout.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wdata_in,
    input  logic [2:0]          funct3,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic [DATA_W-1:0]   data_out,
    output logic                stall,
    output logic                misalign,
    output logic                bus_err,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_wstrb,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata
);

    localparam int NB     = DATA_W / 8;
    localparam int CW_MIN = $clog2(TIMEOUT + 1);
    localparam int CNT_W  = (CW_MIN > 8) ? CW_MIN : 8;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [2:0]          f3_q;
    logic [1:0]          lane_q;
    logic [DATA_W-1:0]   data_q;
    logic                berr_q;
    logic                req_q;
    logic                we_q;
    logic [DATA_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       wstrb_q;

    logic                op_valid;
    logic                is_store;
    logic                align_ok;
    logic                legal;
    logic [NB-1:0]       wstrb_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_d;

    assign op_valid = mem_read | mem_write;
    assign is_store = mem_write;
    // Unsigned widths (BU/HU) are load-only; store funct3 must have bit 2 clear.
    assign legal    = align_ok & ~(is_store & funct3[2]);

    always_comb begin
        align_ok = 1'b0;
        case (funct3)
            3'b000, 3'b100: align_ok = 1'b1;
            3'b001, 3'b101: align_ok = ~addr_in[0];
            3'b010:         align_ok = (addr_in[1:0] == 2'b00);
            default:        align_ok = 1'b0;
        endcase
    end

    always_comb begin
        wstrb_d = '0;
        wdata_d = '0;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    wstrb_d = NB'(1) << addr_in[1:0];
                    wdata_d = {NB{wdata_in[7:0]}};
                end
                2'b01: begin
                    wstrb_d = NB'(3) << addr_in[1:0];
                    wdata_d = {(NB/2){wdata_in[15:0]}};
                end
                default: begin
                    wstrb_d = '1;
                    wdata_d = wdata_in;
                end
            endcase
        end
    end

    assign shifted = dmem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_d = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_d = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_d = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b101:  load_d = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_d = dmem_rdata;
        endcase
    end

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_q <= '0;
                    berr_q <= 1'b0;
                    if (op_valid && legal) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        req_q   <= 1'b1;
                        we_q    <= is_store;
                        addr_q  <= {addr_in[DATA_W-1:2], 2'b00};
                        wdata_q <= wdata_d;
                        wstrb_q <= wstrb_d;
                        f3_q    <= funct3;
                        lane_q  <= addr_in[1:0];
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    // An ack arriving on the final allowed cycle still wins over the abort.
                    if (dmem_ack || (cnt_d == CNT_END)) begin
                        state_q <= RESP;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                        wstrb_q <= '0;
                        berr_q  <= ~dmem_ack;
                        data_q  <= (dmem_ack && !we_q) ? load_d : '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    data_q  <= '0;
                    berr_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_q;
    assign bus_err    = berr_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_wstrb = wstrb_q;
    assign stall      = rst & ((state_q == BUSY) | ((state_q == IDLE) & op_valid & legal));
    assign misalign   = rst & (state_q == IDLE) & op_valid & ~legal;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected events, a monitor
// pops and compares them as the DUT presents requests, responses and misalign pulses.
module tb_mem_access_unit;

    localparam int TO = 4;
    localparam int K_MIS = 0;
    localparam int K_REQ = 1;
    localparam int K_RSP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] data_out;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        berr;
        int          stalls;
    } exp_t;

    exp_t q[$];

    mem_access_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .wdata_in(wdata_in), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .data_out(data_out), .stall(stall),
        .misalign(misalign), .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on RV32I access rules.
    function automatic bit legal_m(bit wr, logic [2:0] f3, logic [31:0] a);
        int sz;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    return 1'b0;
        endcase
        if (wr && f3 >= 3'd4) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] load_m(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3)
            3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
            3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
            3'd4: v = v & 32'hFF;
            3'd5: v = v & 32'hFFFF;
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] strb_m(logic [2:0] f3, logic [31:0] a);
        case (f3)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return 4'(3 << (a % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] swdata_m(logic [2:0] f3, logic [31:0] wd);
        case (f3)
            3'd0:    return (wd & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // lat < 0: memory never acks, so the access must time out.
    task automatic do_op(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                         int lat, logic [31:0] rdv, bit spur);
        exp_t e;
        @(posedge clk); #1;
        dmem_ack  = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr_in   = a;
        wdata_in  = wd;
        e = '{default: 0};
        if (!legal_m(wr, f3, a)) begin
            e.kind = K_MIS;
            q.push_back(e);
            @(posedge clk); #1;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            return;
        end
        e.kind  = K_REQ;
        e.we    = wr;
        e.addr  = a & 32'hFFFF_FFFC;
        e.wdata = wr ? swdata_m(f3, wd) : 32'h0;
        e.strb  = wr ? strb_m(f3, a) : 4'h0;
        q.push_back(e);
        e        = '{default: 0};
        e.kind   = K_RSP;
        e.data   = (lat >= 0 && !wr) ? load_m(f3, a, rdv) : 32'h0;
        e.berr   = (lat < 0);
        e.stalls = (lat < 0) ? TO + 1 : lat + 2;
        q.push_back(e);
        @(posedge clk); #1;
        if (lat < 0) begin
            dmem_rdata = rdv;
            repeat (TO) begin @(posedge clk); #1; end
        end else begin
            repeat (lat) begin @(posedge clk); #1; end
            dmem_rdata = rdv;
            dmem_ack   = 1'b1;
            @(posedge clk); #1;
            dmem_ack   = 1'b0;
        end
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        dmem_rdata = $urandom;
        if (spur) dmem_ack = 1'b1;
    endtask

    task automatic idle(int n, bit spur);
        repeat (n) begin
            @(posedge clk); #1;
            dmem_ack   = spur;
            dmem_rdata = $urandom;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
    endtask

    task automatic take(int kind, string nm, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '{default: 0};
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL %s: got unexpected event kind %0d, expected none pending", nm, kind);
        end else begin
            e = q.pop_front();
            if (e.kind != kind) begin
                fails++;
                $display("FAIL %s: got event kind %0d expected kind %0d", nm, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    initial begin : monitor
        bit   pst;
        bit   preq;
        bit   ok;
        int   sc;
        exp_t e;
        pst = 1'b0; preq = 1'b0; sc = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pst = 1'b0; preq = 1'b0; sc = 0;
                continue;
            end
            if (stall) sc++;
            if (dmem_req && !preq) begin
                take(K_REQ, "req_event", ok, e);
                if (ok) begin
                    chk("req_we", {31'b0, dmem_we}, {31'b0, e.we});
                    chk("req_addr", dmem_addr, e.addr);
                    chk("req_wdata", dmem_wdata, e.wdata);
                    chk("req_wstrb", {28'b0, dmem_wstrb}, {28'b0, e.strb});
                end
            end
            if (misalign) begin
                take(K_MIS, "misalign_event", ok, e);
                chk("misalign_stall", {31'b0, stall}, 32'h0);
                chk("misalign_req", {31'b0, dmem_req}, 32'h0);
            end
            if (pst && !stall) begin
                take(K_RSP, "resp_event", ok, e);
                if (ok) begin
                    chk("resp_data", data_out, e.data);
                    chk("resp_bus_err", {31'b0, bus_err}, {31'b0, e.berr});
                    chk("resp_stall_cycles", sc, e.stalls);
                end
                sc = 0;
            end else begin
                chk("quiet_data_out", data_out, 32'h0);
                chk("quiet_bus_err", {31'b0, bus_err}, 32'h0);
            end
            pst  = stall;
            preq = dmem_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    task automatic chk_all_zero(string nm);
        chk({nm, "_req"}, {31'b0, dmem_req}, 32'h0);
        chk({nm, "_stall"}, {31'b0, stall}, 32'h0);
        chk({nm, "_data_out"}, data_out, 32'h0);
        chk({nm, "_bus_err"}, {31'b0, bus_err}, 32'h0);
        chk({nm, "_misalign"}, {31'b0, misalign}, 32'h0);
        chk({nm, "_we"}, {31'b0, dmem_we}, 32'h0);
        chk({nm, "_wstrb"}, {28'b0, dmem_wstrb}, 32'h0);
        chk({nm, "_addr"}, dmem_addr, 32'h0);
    endtask

    initial begin : stim
        exp_t e;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        do_op(1, 0, 3'b000, 32'h1003, 32'h0, 2, 32'h80FF_1234, 0);
        do_op(0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 1, 32'h0, 0);
        do_op(1, 0, 3'b010, 32'h3001, 32'h0, 0, 32'h0, 0);
        do_op(1, 0, 3'b101, 32'h0010, 32'h0, -1, 32'h5555_AAAA, 0);
        do_op(1, 0, 3'b010, 32'h0040, 32'h0, 0, 32'h1234_5678, 0);
        do_op(1, 0, 3'b010, 32'h0044, 32'h0, 0, 32'hCAFE_F00D, 1);
        do_op(1, 0, 3'b001, 32'h0006, 32'h0, TO - 1, 32'h8001_0000, 0);
        do_op(1, 1, 3'b000, 32'h0101, 32'h0000_00A5, 0, 32'h0, 0);
        do_op(0, 1, 3'b100, 32'h0200, 32'h0, 0, 32'h0, 0);
        idle(3, 1);

        for (int i = 0; i < 150; i++) begin
            int   sel;
            int   lat;
            sel = $urandom_range(0, 2);
            lat = $urandom_range(0, TO);
            if (lat == TO) lat = -1;
            do_op(sel != 1, sel != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  lat, $urandom, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3), 1);
        end

        // Reset while a load is outstanding; the late ack must be ignored.
        @(posedge clk); #1;
        dmem_ack  = 1'b0;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr_in   = 32'h0000_0080;
        e         = '{default: 0};
        e.kind    = K_REQ;
        e.addr    = 32'h0000_0080;
        q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid_busy");
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        dmem_ack   = 1'b1;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("after_late_ack");

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
